// File: rtl/to_polar_sched_pkg.sv
// rtl/to_polar_sched_pkg.sv - shared types and constants for the to_polar scheduler
package to_polar_sched_pkg;

    localparam int CORE_LAT = 24;
    localparam int MAX_CW   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // chan is sized for the largest supported NCH; narrower builds use the low bits
    typedef struct packed {
        logic              valid;
        logic [MAX_CW-1:0] chan;
    } tag_t;

endpackage

// File: rtl/to_polar_sched_rr.sv
// rtl/to_polar_sched_rr.sv - round-robin arbiter, search starts one past ptr
module to_polar_sched_rr
#(
    parameter int NCH = 4,
    parameter int CW  = 2
)
(
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  ptr,
    input  logic           prio_en,
    output logic [NCH-1:0] gnt,
    output logic [CW-1:0]  idx,
    output logic           any
);

    always_comb begin
        logic [CW-1:0] c;
        c   = '0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        if (prio_en && req[0]) begin
            gnt[0] = 1'b1;
            any    = 1'b1;
        end else begin
            for (int k = 1; k <= NCH; k++) begin
                c = CW'((int'(ptr) + k) % NCH);
                if (!any && req[c]) begin
                    gnt[c] = 1'b1;
                    idx    = c;
                    any    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/to_polar_sched.sv
// rtl/to_polar_sched.sv - shares one to_polar core between NCH requesters (TO_POLAR_SCHED_PRIO_EN: ch0 strict priority)
module to_polar_sched
    import to_polar_sched_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 2,
    parameter int IW  = 16,
    parameter int OW  = 16,
    parameter int PW  = 25,
    parameter int LAT = CORE_LAT
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              flush_req,
    output logic              flush_done,
    input  logic [NCH-1:0]    s_valid,
    output logic [NCH-1:0]    s_ready,
    input  logic [NCH*IW-1:0] s_x,
    input  logic [NCH*IW-1:0] s_y,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CW-1:0]     m_chan,
    output logic [OW-1:0]     m_mag,
    output logic [PW-1:0]     m_phase,
    output logic              cor_ce,
    output logic [IW-1:0]     cor_x,
    output logic [IW-1:0]     cor_y,
    output logic              cor_aux,
    input  logic [OW-1:0]     cor_mag,
    input  logic [PW-1:0]     cor_phase,
    input  logic              cor_aux_o,
    output logic              busy,
    output logic              err
);

    localparam int FW = $clog2(LAT + 1);

`ifdef TO_POLAR_SCHED_PRIO_EN
    localparam logic PRIO = 1'b1;
`else
    localparam logic PRIO = 1'b0;
`endif

    state_t         state;
    tag_t           tag [LAT];
    logic [CW-1:0]  rr;
    logic [FW-1:0]  inflight;
    logic [NCH-1:0] gnt;
    logic [CW-1:0]  g;
    logic           any;
    logic           grant_ok;
    logic           accept;
    logic           pop;

    to_polar_sched_rr #(.NCH(NCH), .CW(CW)) u_rr (
        .req     (s_valid),
        .ptr     (rr),
        .prio_en (PRIO),
        .gnt     (gnt),
        .idx     (g),
        .any     (any)
    );

    assign m_valid = tag[LAT-1].valid;
    assign m_chan  = tag[LAT-1].chan[CW-1:0];
    assign m_mag   = cor_mag;
    assign m_phase = cor_phase;

    // a held result freezes the core and the tag line together
    assign cor_ce   = !(m_valid && !m_ready);
    assign grant_ok = (state == RUN) && cor_ce;
    assign s_ready  = grant_ok ? gnt : '0;
    assign accept   = grant_ok && any;
    assign pop      = m_valid && m_ready;

    assign cor_x   = accept ? s_x[int'(g)*IW +: IW] : '0;
    assign cor_y   = accept ? s_y[int'(g)*IW +: IW] : '0;
    assign cor_aux = accept;
    assign busy    = (inflight != '0) || (state == DRAIN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr         <= CW'(NCH - 1);
            inflight   <= '0;
            flush_done <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                tag[i] <= '0;
            end
        end else begin
            flush_done <= 1'b0;
            if (cor_ce) begin
                tag[0].valid <= accept;
                tag[0].chan  <= MAX_CW'(g);
                for (int i = 1; i < LAT; i++) begin
                    tag[i] <= tag[i-1];
                end
            end
            if (accept) begin
                rr <= g;
            end
            if (accept && !pop) begin
                inflight <= inflight + FW'(1);
            end else if (!accept && pop) begin
                inflight <= inflight - FW'(1);
            end
            if (cor_aux_o != m_valid) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (enable) state <= RUN;
                end
                RUN: begin
                    if (flush_req)   state <= DRAIN;
                    else if (!enable) state <= IDLE;
                end
                DRAIN: begin
                    if (inflight == '0 && !m_valid) begin
                        flush_done <= 1'b1;
                        state      <= enable ? RUN : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_to_polar_sched.sv
// tb/tb_to_polar_sched.sv - randomized self-checking bench for to_polar_sched
module tb_to_polar_sched;

    localparam int NCH = 4;
    localparam int CW  = 2;
    localparam int IW  = 16;
    localparam int OW  = 16;
    localparam int PW  = 25;
    localparam int LAT = 24;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
`ifdef TO_POLAR_SCHED_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              flush_req = 1'b0;
    logic              flush_done;
    logic [NCH-1:0]    s_valid = '0;
    logic [NCH-1:0]    s_ready;
    logic [NCH*IW-1:0] s_x = '0;
    logic [NCH*IW-1:0] s_y = '0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [CW-1:0]     m_chan;
    logic [OW-1:0]     m_mag;
    logic [PW-1:0]     m_phase;
    logic              cor_ce;
    logic [IW-1:0]     cor_x;
    logic [IW-1:0]     cor_y;
    logic              cor_aux;
    logic [OW-1:0]     cor_mag;
    logic [PW-1:0]     cor_phase;
    logic              cor_aux_o;
    logic              busy;
    logic              err;

    always #5 clk = ~clk;

    to_polar_sched dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush_req(flush_req),
        .flush_done(flush_done), .s_valid(s_valid), .s_ready(s_ready),
        .s_x(s_x), .s_y(s_y), .m_valid(m_valid), .m_ready(m_ready),
        .m_chan(m_chan), .m_mag(m_mag), .m_phase(m_phase), .cor_ce(cor_ce),
        .cor_x(cor_x), .cor_y(cor_y), .cor_aux(cor_aux), .cor_mag(cor_mag),
        .cor_phase(cor_phase), .cor_aux_o(cor_aux_o), .busy(busy), .err(err)
    );

    // stand-in core: LAT enabled cycles of delay, magnitude with CORDIC-like gain 1.647
    function automatic logic [OW-1:0] core_mag(input logic [IW-1:0] x, input logic [IW-1:0] y);
        int ax;
        int ay;
        ax = int'($signed(x));
        ay = int'($signed(y));
        if (ax < 0) ax = -ax;
        if (ay < 0) ay = -ay;
        return OW'(((ax + ay) * 1647) / 1000);
    endfunction

    function automatic logic [PW-1:0] core_phase(input logic [IW-1:0] y);
        return PW'($signed(y));
    endfunction

    logic [IW-1:0] px [LAT];
    logic [IW-1:0] py [LAT];
    logic          pa [LAT];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                px[i] <= '0;
                py[i] <= '0;
                pa[i] <= 1'b0;
            end
        end else if (cor_ce) begin
            px[0] <= cor_x;
            py[0] <= cor_y;
            pa[0] <= cor_aux;
            for (int i = 1; i < LAT; i++) begin
                px[i] <= px[i-1];
                py[i] <= py[i-1];
                pa[i] <= pa[i-1];
            end
        end
    end

    assign cor_mag   = core_mag(px[LAT-1], py[LAT-1]);
    assign cor_phase = core_phase(py[LAT-1]);
    assign cor_aux_o = pa[LAT-1];

    typedef struct {
        int            ch;
        logic [IW-1:0] x;
        logic [IW-1:0] y;
        int            tag;
    } rec_t;

    rec_t q[$];
    int   acc_log[$];
    int   out_log[$];
    int   rr_m = NCH - 1;
    int   ms = M_IDLE;
    int   ce_cnt = 0;
    int   cyc = 0;
    logic fd_exp = 1'b0;
    bit   hold_data = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // One clock of stimulus: entered just after a falling edge, returns at the next one.
    task automatic step();
        logic           exp_mv;
        logic           en;
        logic           exp_busy;
        logic [NCH-1:0] exp_rdy;
        int             g;
        int             pre;
        rec_t           r;
        if (!hold_data) begin
            s_x = {$urandom(), $urandom()};
            s_y = {$urandom(), $urandom()};
        end
        #1;
        pre    = q.size();
        exp_mv = (pre > 0) && (ce_cnt - q[0].tag == LAT);
        en     = !(exp_mv && !m_ready);
        checks++;
        if (m_valid !== exp_mv) begin
            failures++;
            $display("FAIL m_valid cyc=%0d got=%b want=%b", cyc, m_valid, exp_mv);
        end
        if (exp_mv) begin
            checks++;
            if (m_chan !== CW'(q[0].ch) || m_mag !== core_mag(q[0].x, q[0].y) ||
                m_phase !== core_phase(q[0].y)) begin
                failures++;
                $display("FAIL result cyc=%0d got chan=%0d mag=%h ph=%h want chan=%0d mag=%h ph=%h",
                         cyc, m_chan, m_mag, m_phase, q[0].ch, core_mag(q[0].x, q[0].y),
                         core_phase(q[0].y));
            end
        end
        checks++;
        if (cor_ce !== en) begin
            failures++;
            $display("FAIL cor_ce cyc=%0d got=%b want=%b", cyc, cor_ce, en);
        end
        g = -1;
        if (ms == M_RUN && en) begin
            if (PRIO && s_valid[0]) begin
                g = 0;
            end else begin
                for (int k = 1; k <= NCH; k++) begin
                    int c;
                    c = (rr_m + k) % NCH;
                    if (g < 0 && s_valid[c]) g = c;
                end
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        checks++;
        if (s_ready !== exp_rdy) begin
            failures++;
            $display("FAIL s_ready cyc=%0d got=%b want=%b", cyc, s_ready, exp_rdy);
        end
        if (g >= 0) begin
            checks++;
            if (cor_x !== s_x[g*IW +: IW] || cor_y !== s_y[g*IW +: IW] || cor_aux !== 1'b1) begin
                failures++;
                $display("FAIL core_drive cyc=%0d got x=%h y=%h aux=%b want x=%h y=%h aux=1",
                         cyc, cor_x, cor_y, cor_aux, s_x[g*IW +: IW], s_y[g*IW +: IW]);
            end
        end
        exp_busy = (pre != 0) || (ms == M_DRAIN);
        checks++;
        if (flush_done !== fd_exp || busy !== exp_busy || err !== 1'b0) begin
            failures++;
            $display("FAIL status cyc=%0d got fd=%b busy=%b err=%b want fd=%b busy=%b err=0",
                     cyc, flush_done, busy, err, fd_exp, exp_busy);
        end
        for (int k = 0; k < NCH; k++) begin
            if (s_valid[k] && s_ready[k]) acc_log.push_back(k);
        end
        if (m_valid && m_ready) out_log.push_back(int'(m_chan));
        if (g >= 0) begin
            r.ch  = g;
            r.x   = s_x[g*IW +: IW];
            r.y   = s_y[g*IW +: IW];
            r.tag = ce_cnt;
            q.push_back(r);
            rr_m = g;
        end
        if (exp_mv && m_ready) void'(q.pop_front());
        fd_exp = 1'b0;
        case (ms)
            M_IDLE:  if (enable) ms = M_RUN;
            M_RUN:   if (flush_req) ms = M_DRAIN; else if (!enable) ms = M_IDLE;
            default: if (pre == 0 && !exp_mv) begin
                         fd_exp = 1'b1;
                         ms = enable ? M_RUN : M_IDLE;
                     end
        endcase
        if (en) ce_cnt++;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_valid = '0;
        flush_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        rr_m = NCH - 1;
        ms = M_IDLE;
        fd_exp = 1'b0;
        cyc++;
    endtask

    task automatic drain();
        s_valid = '0;
        m_ready = 1'b1;
        flush_req = 1'b0;
        enable = 1'b1;
        for (int n = 0; n < 200 && (q.size() != 0 || ms != M_RUN); n++) step();
    endtask

    task automatic test_reset();
        do_reset();
        enable = 1'b0;
        s_valid = '1;
        #1;
        checks++;
        if (s_ready !== '0 || m_valid !== 1'b0 || busy !== 1'b0 || flush_done !== 1'b0 ||
            err !== 1'b0 || cor_ce !== 1'b1) begin
            failures++;
            $display("FAIL reset_state got rdy=%b mv=%b busy=%b fd=%b err=%b ce=%b want 0 0 0 0 0 1",
                     s_ready, m_valid, busy, flush_done, err, cor_ce);
        end
        @(negedge clk);
        step();
        step();
        s_valid = '0;
    endtask

    task automatic test_fairness();
        int bad;
        enable = 1'b1;
        m_ready = 1'b1;
        s_valid = '0;
        step();
        acc_log.delete();
        out_log.delete();
        s_valid = '1;
        repeat (40) step();
        s_valid = '0;
        for (int n = 0; n < 100 && out_log.size() < 40; n++) step();
        checks++;
        if (acc_log.size() != 40 || out_log.size() != 40) begin
            failures++;
            $display("FAIL fair_count got acc=%0d out=%0d want 40 40", acc_log.size(), out_log.size());
        end else begin
            bad = 0;
            for (int k = 0; k < 40; k++) begin
                if (acc_log[k] != k % NCH || out_log[k] != k % NCH) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL fair_order got %0d out-of-order entries want 0", bad);
            end
        end
    endtask

    task automatic test_single();
        int acc_cyc;
        int d;
        drain();
        hold_data = 1'b1;
        s_x = 64'h0000_4000_0000_0000;
        s_y = '0;
        s_valid = 4'b0100;
        acc_log.delete();
        acc_cyc = cyc;
        step();
        s_valid = '0;
        checks++;
        if (acc_log.size() != 1 || acc_log[0] != 2) begin
            failures++;
            $display("FAIL single_accept got n=%0d want one accept on ch2", acc_log.size());
        end
        for (int n = 0; n < 40 && !m_valid; n++) step();
        d = int'(m_mag) - 26984;
        checks++;
        if (m_valid !== 1'b1 || cyc - acc_cyc != LAT || m_chan !== 2'd2 ||
            d < -2 || d > 2 || m_phase !== '0) begin
            failures++;
            $display("FAIL single got mv=%b lat=%0d chan=%0d mag=%0d ph=%h want 1 %0d 2 26984 0",
                     m_valid, cyc - acc_cyc, m_chan, m_mag, m_phase, LAT);
        end
        hold_data = 1'b0;
        drain();
    endtask

    task automatic test_backpressure();
        logic [CW-1:0] hc;
        logic [OW-1:0] hm;
        logic [PW-1:0] hp;
        int            bad;
        drain();
        acc_log.delete();
        out_log.delete();
        s_valid = '1;
        repeat (30) step();
        m_ready = 1'b0;
        hc = m_chan;
        hm = m_mag;
        hp = m_phase;
        for (int n = 0; n < 10; n++) begin
            step();
            checks++;
            if (m_valid !== 1'b1 || m_chan !== hc || m_mag !== hm || m_phase !== hp ||
                cor_ce !== 1'b0 || s_ready !== '0 || dut.inflight !== 5'd24) begin
                failures++;
                $display("FAIL stall n=%0d got mv=%b chan=%0d mag=%h ce=%b rdy=%b inflight=%0d want held, ce=0 rdy=0 inflight=24",
                         n, m_valid, m_chan, m_mag, cor_ce, s_ready, dut.inflight);
            end
        end
        m_ready = 1'b1;
        repeat (10) step();
        drain();
        bad = 0;
        if (acc_log.size() == out_log.size()) begin
            for (int k = 0; k < acc_log.size(); k++) if (acc_log[k] != out_log[k]) bad++;
        end
        checks++;
        if (acc_log.size() != out_log.size() || bad != 0) begin
            failures++;
            $display("FAIL bp_stream got acc=%0d out=%0d diffs=%0d want equal streams",
                     acc_log.size(), out_log.size(), bad);
        end
    endtask

    task automatic test_flush();
        drain();
        acc_log.delete();
        out_log.delete();
        s_valid = '1;
        repeat (12) step();
        checks++;
        if (acc_log.size() != 12 || dut.inflight !== 5'd12) begin
            failures++;
            $display("FAIL flush_fill got acc=%0d inflight=%0d want 12 12", acc_log.size(), dut.inflight);
        end
        s_valid = '0;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        s_valid = '1;
        acc_log.delete();
        for (int n = 0; n < 60 && !flush_done; n++) step();
        checks++;
        if (flush_done !== 1'b1 || acc_log.size() != 0 || out_log.size() != 12) begin
            failures++;
            $display("FAIL flush got fd=%b grants=%0d results=%0d want 1 0 12",
                     flush_done, acc_log.size(), out_log.size());
        end
        step();
        checks++;
        if (acc_log.size() != 1) begin
            failures++;
            $display("FAIL flush_resume got grants=%0d want 1", acc_log.size());
        end
        drain();
    endtask

    task automatic test_prio();
        int n0;
        int n3;
        int e0;
        drain();
        acc_log.delete();
        s_valid = 4'b1001;
        repeat (20) step();
        s_valid = '0;
        n0 = 0;
        n3 = 0;
        foreach (acc_log[k]) begin
            if (acc_log[k] == 0) n0++;
            if (acc_log[k] == 3) n3++;
        end
        e0 = PRIO ? 20 : 10;
        checks++;
        if (n0 != e0 || n3 != 20 - e0) begin
            failures++;
            $display("FAIL prio got ch0=%0d ch3=%0d want %0d %0d", n0, n3, e0, 20 - e0);
        end
        drain();
    endtask

    task automatic test_random();
        int bad;
        drain();
        acc_log.delete();
        out_log.delete();
        for (int n = 0; n < 400; n++) begin
            s_valid   = NCH'($urandom());
            m_ready   = ($urandom() % 4) != 0;
            enable    = ($urandom() % 16) != 0;
            flush_req = ($urandom() % 50) == 0;
            step();
        end
        drain();
        bad = 0;
        if (acc_log.size() == out_log.size()) begin
            for (int k = 0; k < acc_log.size(); k++) if (acc_log[k] != out_log[k]) bad++;
        end
        checks++;
        if (acc_log.size() != out_log.size() || bad != 0 || err !== 1'b0) begin
            failures++;
            $display("FAIL random_stream got acc=%0d out=%0d diffs=%0d err=%b want equal, err=0",
                     acc_log.size(), out_log.size(), bad, err);
        end
    endtask

    task automatic test_reset_mid_run();
        drain();
        s_valid = '1;
        repeat (20) step();
        checks++;
        if (dut.inflight !== 5'd20) begin
            failures++;
            $display("FAIL midrun_fill got inflight=%0d want 20", dut.inflight);
        end
        do_reset();
        s_valid = '0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset got mv=%b busy=%b want 0 0", m_valid, busy);
        end
        @(negedge clk);
        out_log.delete();
        repeat (40) step();
        checks++;
        if (out_log.size() != 0) begin
            failures++;
            $display("FAIL midrun_results got %0d results want 0", out_log.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_fairness();
        test_single();
        test_backpressure();
        test_flush();
        test_prio();
        test_random();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/to_polar_sched.md
Name: to_polar_sched

Overview:
- Round-robin scheduler that shares one to_polar CORDIC pipeline (default 22 stages, latency 24) between NCH sample requesters.
- Accepts one (x,y) sample per cycle from one requester and drives the core's clock enable.
- Tracks channel ID and valid for every sample in flight with a tag delay line.
- Returns results as one backpressured stream tagged with the channel ID. Sits between the per-channel downconverters and the magnitude/phase consumers.

Parameters:
- NCH, 4, number of requesters (2..8)
- CW, 2, channel ID width, equals clog2(NCH)
- IW, 16, input sample width
- OW, 16, magnitude width
- PW, 25, phase width
- LAT, 24, core latency in enabled cycles (NSTAGES+2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  0 = no new grants
- flush_req  in  1  pulse: stop accepting, drain pipeline
- flush_done  out  1  one-cycle pulse when drain completes
- s_valid  in  NCH  per-channel sample valid
- s_ready  out  NCH  per-channel accept
- s_x  in  NCH*IW  packed signed x, ch0 in LSBs
- s_y  in  NCH*IW  packed signed y
- m_valid  out  1  result valid
- m_ready  in  1  result accept
- m_chan  out  CW  result channel ID
- m_mag  out  OW  result magnitude
- m_phase  out  PW  result phase
- cor_ce  out  1  core clock enable
- cor_x, cor_y  out  IW each  core inputs
- cor_aux  out  1  core aux input (sample valid)
- cor_mag  in  OW  core magnitude
- cor_phase  in  PW  core phase
- cor_aux_o  in  1  core aux output
- busy  out  1  in-flight count nonzero or state not RUN/IDLE
- err  out  1  sticky tag/aux mismatch

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; tag line, rr pointer (=NCH-1), in-flight count, flush_done and err cleared. s_ready=0, m_valid=0. Core must share the same reset. Reset mid-operation discards all in-flight samples, with no outputs emitted.
- Stall: cor_ce = !(m_valid && !m_ready). The tag line shifts only when cor_ce=1, so the core and the tags freeze together.
- States:
  - IDLE: enable=1 goes to RUN.
  - RUN: grants allowed. enable=0 goes to IDLE; in-flight samples still complete. flush_req goes to DRAIN and takes priority over enable.
  - DRAIN: no grants. When in-flight=0 and m_valid=0, pulse flush_done for one cycle, then go to RUN if enable=1, else IDLE.
- Arbitration: combinational one-hot grant to the first s_valid searching from rr+1 modulo NCH. s_ready[g]=1 only when the state is RUN and cor_ce=1, and only for the granted channel g.
- Pointer update: rr is set to g only on an accepted transfer (s_valid[g]&&s_ready[g]).
- Core drive: cor_x/cor_y are the granted channel's data, or 0 when nothing is granted. cor_aux=1 only on accept. Tag entry 0 loads {accept, g}.
- Output: m_valid = tag[LAT-1].valid; m_chan = tag[LAT-1].chan; m_mag/m_phase pass cor_mag/cor_phase through. Latency from accept to m_valid is exactly LAT enabled cycles.
- In-flight count (width clog2(LAT+1)): +1 on accept, -1 on m_valid&&m_ready, unchanged when both occur in the same cycle. It never exceeds LAT.
- err: set when cor_aux_o != tag[LAT-1].valid. It is sticky until reset.
- s_ready depends combinationally on s_valid. Requesters must not make s_valid depend on s_ready.

Optional Feature:
- Macro: TO_POLAR_SCHED_PRIO_EN.
- Defined: channel 0 has strict priority and wins whenever s_valid[0]=1. The remaining channels are round-robin among themselves.
- Undefined: pure round robin as above.

Decomposition:
- Package to_polar_sched_pkg holds:
  - the tag struct {valid, chan}
  - the state enum IDLE/RUN/DRAIN
  - localparam CORE_LAT=24
- One sub-module, to_polar_sched_rr: a parameterised round-robin arbiter with inputs req[NCH], ptr, and prio-enable, and outputs the one-hot grant and the encoded index.

Test Plan:
- Single sample: ch2 sends x=0x4000, y=0, m_ready=1. Expect m_valid exactly 24 cycles after accept, m_chan=2, m_mag≈0x4000·1.647 scaled per core, m_phase≈0.
- Fairness: all four channels hold s_valid=1 for 40 cycles. Expect accept order 0,1,2,3,0,... with one accept per cycle, and m_chan sequence identical 24 cycles later.
- Backpressure: drop m_ready for 10 cycles while the pipe is full. Expect cor_ce=0 and s_ready=0 throughout, m_* held stable, no loss or duplication, in-flight count stays 24.
- Flush: pulse flush_req with 12 samples in flight. Expect no further grants, 12 results, flush_done one cycle after the last handshake, then return to RUN.
- Reset mid-run: rst_n=0 for one cycle with 20 samples in flight. Expect m_valid=0, busy=0, and no results afterwards.
- PRIO_EN build: ch0 and ch3 continuously valid. Expect ch0 always granted and ch3 starved. Without the macro, they alternate.
